// File: rtl/generic_bus_ram_responder.sv
// Responder end of generic_bus_if: word-addressed local RAM with programmable wait states.
// One request at a time: IDLE latches it, WAIT counts down, RESP completes and commits writes.
module generic_bus_ram_responder #(
   parameter int unsigned ADDR_BITS = 10,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ren,
   input  logic        wen,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byte_en,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        bus_err
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   localparam int unsigned Words   = 2 ** ADDR_BITS;
   localparam logic [32:0] WordsW  = 33'(Words);
   localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);
   localparam logic [31:0] OorData = 32'hBAD1_BAD1;

   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] idx_q;
   logic [31:0]          wdata_q;
   logic [3:0]           be_q;
   logic                 write_q;
   logic                 oor_q;
   logic                 proto_q;
   logic [31:0]          rdata_q;

   logic [31:0] mem [Words];

   logic [31:0]          offset;
   logic [32:0]          word_off;
   logic [ADDR_BITS-1:0] idx_in;
   logic                 oor_in;
   logic                 req;
   logic                 latch;
   logic                 rd_load;
   logic                 ram_we;

   // Range check on the live address; only the latched result is ever used.
   assign offset   = addr - BASE_ADDR;
   assign word_off = {1'b0, offset} >> 2;
   assign idx_in   = word_off[ADDR_BITS-1:0];
   assign oor_in   = (addr < BASE_ADDR) || (word_off >= WordsW);

   assign req     = ren | wen;
   assign latch   = (state_q == StIdle) && req;
   assign rd_load = (state_q == StWait) && (state_d == StResp);
   assign ram_we  = (state_q == StResp) && write_q && !oor_q && !proto_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (req) begin
               state_d = StWait;
               cnt_d   = CntLoad;
            end
         end
         StWait: begin
            // Dropping both strobes mid-wait is an abort: nothing is committed.
            if (!req) begin
               state_d = StIdle;
            end else if (cnt_q == 4'd0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         write_q <= 1'b0;
         oor_q   <= 1'b0;
         proto_q <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch) begin
            idx_q   <= idx_in;
            wdata_q <= wdata;
            be_q    <= byte_en;
            write_q <= wen & ~ren;
            oor_q   <= oor_in;
            proto_q <= ren & wen;
         end
         if (rd_load) begin
            rdata_q <= mem[idx_q];
         end
      end
   end

   // RAM contents survive reset; the write lands on the edge that ends RESP.
   always_ff @(posedge CLK) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      busy    = 1'b0;
      rdata   = 32'd0;
      bus_err = 1'b0;
      case (state_q)
         StIdle: busy = req;
         StWait: busy = 1'b1;
         StResp: begin
            bus_err = oor_q | proto_q;
            if (proto_q) begin
               rdata = 32'd0;
            end else if (oor_q) begin
               rdata = OorData;
            end else begin
               rdata = rdata_q;
            end
         end
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_generic_bus_ram_responder.sv
// Bench for generic_bus_ram_responder: two instances (LATENCY=2 at base 0, LATENCY=1 at base
// 0x1000), directed protocol cases followed by random traffic against an array memory model.
module tb_generic_bus_ram_responder;

   logic        CLK;
   logic        nRST;
   logic        a_ren, a_wen, b_ren, b_wen;
   logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
   logic [3:0]  a_be, b_be;
   logic [31:0] a_rdata, b_rdata;
   logic        a_busy, a_err, b_busy, b_err;

   int nvec = 0;
   int nmis = 0;
   int cyc  = 0;

   logic [31:0] mdl [2][16];

   generic_bus_ram_responder #(
      .ADDR_BITS (10),
      .LATENCY   (2),
      .BASE_ADDR (32'h0000_0000)
   ) u_dut_a (
      .CLK     (CLK),
      .nRST    (nRST),
      .ren     (a_ren),
      .wen     (a_wen),
      .addr    (a_addr),
      .wdata   (a_wdata),
      .byte_en (a_be),
      .rdata   (a_rdata),
      .busy    (a_busy),
      .bus_err (a_err)
   );

   generic_bus_ram_responder #(
      .ADDR_BITS (8),
      .LATENCY   (1),
      .BASE_ADDR (32'h0000_1000)
   ) u_dut_b (
      .CLK     (CLK),
      .nRST    (nRST),
      .ren     (b_ren),
      .wen     (b_wen),
      .addr    (b_addr),
      .wdata   (b_wdata),
      .byte_en (b_be),
      .rdata   (b_rdata),
      .busy    (b_busy),
      .bus_err (b_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nmis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit in_range(input bit sel, input logic [31:0] ad);
      longint unsigned base = sel ? 64'h1000 : 64'h0;
      longint unsigned nw   = sel ? 64'd256 : 64'd1024;
      longint unsigned a    = {32'd0, ad};
      if (a < base) return 1'b0;
      return ((a - base) >> 2) < nw;
   endfunction

   function automatic int word_of(input bit sel, input logic [31:0] ad);
      logic [31:0] base = sel ? 32'h1000 : 32'h0;
      return int'((ad - base) >> 2);
   endfunction

   task automatic drive(input bit sel, input logic r, input logic w, input logic [31:0] ad,
                        input logic [31:0] wd, input logic [3:0] be);
      if (sel) begin
         b_ren = r; b_wen = w; b_addr = ad; b_wdata = wd; b_be = be;
      end else begin
         a_ren = r; a_wen = w; a_addr = ad; a_wdata = wd; a_be = be;
      end
   endtask

   // One complete transaction, entered #1 after a rising edge; checks latency, bus_err and data.
   task automatic op(input bit sel, input logic r, input logic w, input logic [31:0] ad,
                     input logic [31:0] wd, input logic [3:0] be, input string tag,
                     output int done);
      int          n   = 0;
      bit          got = 1'b0;
      int          lat = sel ? 1 : 2;
      logic [31:0] rd;
      logic        er;
      bit          oor = !in_range(sel, ad);
      bit          pro = r & w;
      drive(sel, r, w, ad, wd, be);
      while (!got && n < 40) begin
         @(negedge CLK);
         if ((sel ? b_busy : a_busy) === 1'b0) got = 1'b1;
         else begin
            n++;
            @(posedge CLK);
            #1;
         end
      end
      check({tag, " handshake"}, {31'd0, got}, 32'd1);
      rd   = sel ? b_rdata : a_rdata;
      er   = sel ? b_err : a_err;
      done = cyc;
      @(posedge CLK);
      #1;
      drive(sel, 1'b0, 1'b0, ad, wd, be);
      check({tag, " latency"}, 32'(n), 32'(lat + 1));
      check({tag, " bus_err"}, {31'd0, er}, {31'd0, oor | pro});
      if (pro) check({tag, " rdata"}, rd, 32'd0);
      else if (oor) check({tag, " rdata"}, rd, 32'hBAD1_BAD1);
      else if (r) check({tag, " rdata"}, rd, mdl[sel][word_of(sel, ad)]);
      if (w && !r && !oor) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mdl[sel][word_of(sel, ad)][8*i +: 8] = wd[8*i +: 8];
      end
   endtask

   initial begin
      int          d, t0, d1, d2, kind, idx;
      bit          sel;
      logic        r, w;
      logic [31:0] ad, wd, base;
      logic [3:0]  be;

      nRST = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(1'b1, 1'b0, 1'b0, 32'h1000, 32'd0, 4'd0);
      #3;
      check("reset a busy", {31'd0, a_busy}, 32'd0);
      check("reset a rdata", a_rdata, 32'd0);
      check("reset a bus_err", {31'd0, a_err}, 32'd0);
      check("reset b busy", {31'd0, b_busy}, 32'd0);
      #20;
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      for (int k = 0; k < 16; k++) begin
         op(1'b0, 1'b0, 1'b1, 32'(4 * k), $urandom, 4'hF, "fill a", d);
         op(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(4 * k), $urandom, 4'hF, "fill b", d);
      end

      op(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "write 0x10", d);
      op(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF, "read 0x10", d);
      op(1'b0, 1'b0, 1'b1, 32'h10, 32'h00AA_0000, 4'b0100, "partial write", d);
      check("partial model", mdl[0][4], 32'hDEAA_BEEF);
      op(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF, "read partial", d);
      op(1'b0, 1'b1, 1'b0, 32'h1000, 32'd0, 4'hF, "read oor", d);
      op(1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 4'hF, "read 0x0", d);
      op(1'b0, 1'b0, 1'b1, 32'h1010, 32'h1234_5678, 4'hF, "write oor", d);
      op(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF, "read after oor", d);

      // Abort: drop wen in the first WAIT cycle.
      drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
      @(negedge CLK);
      check("abort busy idle", {31'd0, a_busy}, 32'd1);
      @(posedge CLK);
      #1;
      drive(1'b0, 1'b0, 1'b0, 32'h20, 32'hCAFE_F00D, 4'hF);
      @(negedge CLK);
      check("abort busy wait", {31'd0, a_busy}, 32'd1);
      @(negedge CLK);
      check("abort back to idle", {31'd0, a_busy}, 32'd0);
      @(posedge CLK);
      #1;
      op(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 4'hF, "read after abort", d);

      // Reset during the WAIT of a write.
      drive(1'b0, 1'b0, 1'b1, 32'h24, 32'h5555_AAAA, 4'hF);
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      nRST = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h24, 32'h5555_AAAA, 4'hF);
      #1;
      check("mid reset busy", {31'd0, a_busy}, 32'd0);
      check("mid reset rdata", a_rdata, 32'd0);
      check("mid reset bus_err", {31'd0, a_err}, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      op(1'b0, 1'b1, 1'b0, 32'h24, 32'd0, 4'hF, "read after reset", d);

      op(1'b0, 1'b1, 1'b1, 32'h28, 32'h0BAD_0BAD, 4'hF, "ren and wen", d);
      op(1'b0, 1'b1, 1'b0, 32'h28, 32'd0, 4'hF, "read after proto", d);

      // LATENCY=1 back-to-back reads: done at t+2 and t+5.
      t0 = cyc;
      op(1'b1, 1'b1, 1'b0, 32'h1000, 32'd0, 4'hF, "b2b first", d1);
      op(1'b1, 1'b1, 1'b0, 32'h1004, 32'd0, 4'hF, "b2b second", d2);
      check("b2b first done", 32'(d1 - t0), 32'd2);
      check("b2b second done", 32'(d2 - t0), 32'd5);
      op(1'b1, 1'b1, 1'b0, 32'h0FFC, 32'd0, 4'hF, "read below base", d);
      op(1'b1, 1'b1, 1'b0, 32'h1400, 32'd0, 4'hF, "read above top", d);

      for (int k = 0; k < 120; k++) begin
         sel  = (k % 3) == 2;
         base = sel ? 32'h1000 : 32'h0;
         kind = int'($urandom_range(0, 9));
         idx  = int'($urandom_range(0, 15));
         ad   = base + 32'(4 * idx) + 32'($urandom_range(0, 3));
         wd   = $urandom;
         be   = 4'($urandom_range(0, 15));
         r    = kind < 5;
         w    = !r;
         if (kind == 0) begin
            if (sel && $urandom_range(0, 1) == 0) ad = 32'($urandom_range(0, 32'h0FFF));
            else ad = base + (sel ? 32'h400 : 32'h1000) + ($urandom & 32'h000F_FFFF);
         end else if (kind == 1) begin
            r = 1'b1;
            w = 1'b1;
         end
         op(sel, r, w, ad, wd, be, $sformatf("rand %0d", k), d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
